// File: rtl/counter_period_averager.sv
// Moving-average filter for completed period counts. It keeps a window of the
// last 2^LOG2_DEPTH accepted periods, rejects outliers once the window is
// full, and drives the averaged period to the trigger stage.
module counter_period_averager #(
    parameter int COUNTER_WIDTH    = 32,
    parameter int LOG2_DEPTH       = 3,
    parameter int MAX_REJECT       = 4,
    parameter int REJECT_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        period_strobe,
    input  logic [COUNTER_WIDTH-1:0]    last_counter,
    input  logic [COUNTER_WIDTH-1:0]    tolerance,
    output logic [COUNTER_WIDTH-1:0]    reference_counter,
    output logic                        reference_valid,
    output logic [LOG2_DEPTH:0]         fill_level,
    output logic [REJECT_CNT_WIDTH-1:0] reject_count
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = COUNTER_WIDTH + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;
    localparam int CONS_W = $clog2(MAX_REJECT + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                      state_reg, state_next;
    logic [SUM_W-1:0]            sum_reg, sum_next;
    logic [LOG2_DEPTH-1:0]       ptr_reg, ptr_next;
    logic [FILL_W-1:0]           fill_reg, fill_next;
    logic [COUNTER_WIDTH-1:0]    ref_reg, ref_next;
    logic                        valid_reg, valid_next;
    logic [REJECT_CNT_WIDTH-1:0] rej_reg, rej_next;
    logic [CONS_W-1:0]           cons_reg, cons_next;

    // Stage 1 holds the captured sample, its reject verdict and the oldest entry
    logic                        s1_valid_reg, s1_valid_next;
    logic [COUNTER_WIDTH-1:0]    s1_sample_reg;
    logic                        s1_reject_reg, s1_reject_next;
    logic [COUNTER_WIDTH-1:0]    s1_oldest_reg;

    logic [COUNTER_WIDTH-1:0]    ring_mem [DEPTH];
    logic                        wr_en;
    logic [LOG2_DEPTH-1:0]       wr_addr;
    logic [COUNTER_WIDTH-1:0]    sample_diff;
    logic [SUM_W-1:0]            sum_acc, sum_roll;
    logic [FILL_W-1:0]           fill_inc;
    logic [CONS_W-1:0]           cons_inc;

    // Absolute distance of the incoming sample from the current reference
    always_comb begin
        sample_diff    = (last_counter >= ref_reg) ? (last_counter - ref_reg)
                                                   : (ref_reg - last_counter);
        s1_reject_next = (tolerance != '0) && (sample_diff > tolerance);
    end

    // Next-state and commit logic; enable low dominates clear, clear dominates commits
    always_comb begin
        state_next    = state_reg;
        sum_next      = sum_reg;
        ptr_next      = ptr_reg;
        fill_next     = fill_reg;
        ref_next      = ref_reg;
        valid_next    = valid_reg;
        rej_next      = rej_reg;
        cons_next     = cons_reg;
        s1_valid_next = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = ptr_reg;
        // Modular arithmetic is safe: the true rolled sum always fits SUM_W bits
        sum_acc       = sum_reg + SUM_W'(s1_sample_reg);
        sum_roll      = sum_acc - SUM_W'(s1_oldest_reg);
        fill_inc      = fill_reg + 1'b1;
        cons_inc      = cons_reg + 1'b1;

        if (!enable) begin
            state_next = IDLE;
            sum_next   = '0;
            ptr_next   = '0;
            fill_next  = '0;
            ref_next   = '0;
            valid_next = 1'b0;
            cons_next  = '0;
        end else if (clear) begin
            state_next = FILL;
            sum_next   = '0;
            ptr_next   = '0;
            fill_next  = '0;
            ref_next   = '0;
            valid_next = 1'b0;
            cons_next  = '0;
        end else begin
            // Zero periods are start-up artefacts, not outliers
            s1_valid_next = period_strobe && (last_counter != '0);
            case (state_reg)
                IDLE: state_next = FILL;
                FILL: begin
                    if (s1_valid_reg) begin
                        wr_en     = 1'b1;
                        sum_next  = sum_acc;
                        ptr_next  = ptr_reg + 1'b1;
                        fill_next = fill_inc;
                        if (fill_inc == FILL_W'(DEPTH)) begin
                            state_next = RUN;
                            ref_next   = sum_acc[SUM_W-1:LOG2_DEPTH];
                            valid_next = 1'b1;
                        end else begin
                            ref_next   = s1_sample_reg;
                            valid_next = 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (s1_valid_reg) begin
                        if (!s1_reject_reg) begin
                            wr_en      = 1'b1;
                            sum_next   = sum_roll;
                            ptr_next   = ptr_reg + 1'b1;
                            ref_next   = sum_roll[SUM_W-1:LOG2_DEPTH];
                            valid_next = 1'b1;
                            cons_next  = '0;
                        end else begin
                            if (rej_reg != '1)
                                rej_next = rej_reg + 1'b1;
                            if (cons_inc == CONS_W'(MAX_REJECT)) begin
                                // Persistent disagreement: restart from this sample
                                state_next = FILL;
                                wr_en      = 1'b1;
                                wr_addr    = '0;
                                sum_next   = SUM_W'(s1_sample_reg);
                                ptr_next   = LOG2_DEPTH'(1);
                                fill_next  = FILL_W'(1);
                                ref_next   = s1_sample_reg;
                                valid_next = 1'b0;
                                cons_next  = '0;
                            end else begin
                                cons_next  = cons_inc;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg    <= IDLE;
            sum_reg      <= '0;
            ptr_reg      <= '0;
            fill_reg     <= '0;
            ref_reg      <= '0;
            valid_reg    <= 1'b0;
            rej_reg      <= '0;
            cons_reg     <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sum_reg      <= sum_next;
            ptr_reg      <= ptr_next;
            fill_reg     <= fill_next;
            ref_reg      <= ref_next;
            valid_reg    <= valid_next;
            rej_reg      <= rej_next;
            cons_reg     <= cons_next;
            s1_valid_reg <= s1_valid_next;
        end
    end

    // Stage-1 data capture; validity is tracked separately so no reset is needed
    always_ff @(posedge clk) begin
        s1_sample_reg <= last_counter;
        s1_reject_reg <= s1_reject_next;
    end

    // Window RAM; reading at the post-commit pointer keeps back-to-back samples correct
    always_ff @(posedge clk) begin
        if (wr_en)
            ring_mem[wr_addr] <= s1_sample_reg;
        s1_oldest_reg <= ring_mem[ptr_next];
    end

    assign reference_counter = ref_reg;
    assign reference_valid   = valid_reg;
    assign fill_level        = fill_reg;
    assign reject_count      = rej_reg;

endmodule

// File: tb/tb_counter_period_averager.sv
// Directed bench for counter_period_averager: a queue-based window model predicts
// outputs at stimulus time, and they are compared after each commit.
module tb_counter_period_averager;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        clear;
    logic        period_strobe;
    logic [31:0] last_counter;
    logic [31:0] tolerance;
    logic [31:0] reference_counter;
    logic        reference_valid;
    logic [3:0]  fill_level;
    logic [15:0] reject_count;

    always #5 clk = ~clk;

    counter_period_averager dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .enable            (enable),
        .clear             (clear),
        .period_strobe     (period_strobe),
        .last_counter      (last_counter),
        .tolerance         (tolerance),
        .reference_counter (reference_counter),
        .reference_valid   (reference_valid),
        .fill_level        (fill_level),
        .reject_count      (reject_count)
    );

    typedef struct {
        logic [3:0]  fill;
        logic [31:0] refc;
        logic        valid;
        logic [15:0] rej;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    // Behavioural window model
    longint win[$];
    bit     m_run;
    longint m_ref;
    bit     m_valid;
    int     m_rej;
    int     m_cons;

    function automatic void model_reset(bit keep_rej);
        win.delete();
        m_run = 0; m_ref = 0; m_valid = 0; m_cons = 0;
        if (!keep_rej) m_rej = 0;
    endfunction

    function automatic longint win_avg();
        longint s = 0;
        foreach (win[i]) s += win[i];
        return s / 8;
    endfunction

    function automatic void model_apply(longint v);
        longint diff;
        longint tol = longint'(tolerance);
        if (v == 0) return;
        if (!m_run) begin
            win.push_back(v);
            if (win.size() == 8) begin
                m_run = 1; m_ref = win_avg(); m_valid = 1;
            end else begin
                m_ref = v; m_valid = 0;
            end
        end else begin
            diff = (v > m_ref) ? v - m_ref : m_ref - v;
            if (tol == 0 || diff <= tol) begin
                void'(win.pop_front());
                win.push_back(v);
                m_ref = win_avg(); m_valid = 1; m_cons = 0;
            end else begin
                if (m_rej < 65535) m_rej++;
                m_cons++;
                if (m_cons == 4) begin
                    win.delete(); win.push_back(v);
                    m_run = 0; m_ref = v; m_valid = 0; m_cons = 0;
                end
            end
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.fill  = 4'(win.size());
        e.refc  = 32'(m_ref);
        e.valid = m_valid;
        e.rej   = 16'(m_rej);
        sb.push_back(e);
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard observed empty expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (fill_level === e.fill) else begin
                errors++;
                $error("FAIL %s fill_level observed %0d expected %0d", tag, fill_level, e.fill);
            end
            checks++;
            assert (reference_counter === e.refc) else begin
                errors++;
                $error("FAIL %s reference_counter observed %0d expected %0d", tag, reference_counter, e.refc);
            end
            checks++;
            assert (reference_valid === e.valid) else begin
                errors++;
                $error("FAIL %s reference_valid observed %0b expected %0b", tag, reference_valid, e.valid);
            end
            checks++;
            assert (reject_count === e.rej) else begin
                errors++;
                $error("FAIL %s reject_count observed %0d expected %0d", tag, reject_count, e.rej);
            end
        end
        $display("txn %s: fill=%0d ref=%0d valid=%0b rej=%0d", tag, fill_level,
                 reference_counter, reference_valid, reject_count);
    endtask

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Single strobe, then idle so strobes are spaced 5 cycles apart
    task automatic strobe_spaced(input logic [31:0] v, input string tag, input bit early);
        period_strobe = 1'b1;
        last_counter  = v;
        model_apply(longint'(v));
        push_expect();
        @(posedge clk); #1;
        period_strobe = 1'b0;
        last_counter  = '0;
        if (early) check_val({tag, "_valid_early"}, 32'(reference_valid), 32'd0);
        @(posedge clk); #1;
        check_out(tag);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Strobes on consecutive cycles: value base + i*step for i in 0..n-1
    task automatic burst(input int n, input logic [31:0] base, input logic [31:0] step, input string tag);
        period_strobe = 1'b1;
        last_counter  = base;
        model_apply(longint'(base));
        push_expect();
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            if (i >= 1) check_out($sformatf("%s_%0d", tag, i - 1));
            if (i < n - 1) begin
                last_counter = base + 32'(i + 1) * step;
                model_apply(longint'(last_counter));
                push_expect();
            end else begin
                period_strobe = 1'b0;
                last_counter  = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        model_reset(1'b1);
        push_expect();
        @(posedge clk); #1;
        clear = 1'b0;
        check_out(tag);
        @(posedge clk); #1;
    endtask

    task automatic fill_with(input logic [31:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) strobe_spaced(v, $sformatf("%s_%0d", tag, i), 1'b0);
    endtask

    initial begin
        aresetn = 1'b0; enable = 1'b0; clear = 1'b0;
        period_strobe = 1'b0; last_counter = '0; tolerance = '0;
        model_reset(1'b0);
        repeat (2) @(posedge clk);
        #1;
        push_expect();
        check_out("reset");
        aresetn = 1'b1; enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Fill: fill_level 1..8, valid exactly two cycles after the 8th strobe
        fill_with(32'd1000, 7, "fill");
        strobe_spaced(32'd1000, "fill_7", 1'b1);
        check_val("fill_ref", reference_counter, 32'd1000);

        // Moving average climbing by one per strobe
        fill_with(32'd1008, 8, "avg1008");
        check_val("avg_ref_1008", reference_counter, 32'd1008);

        // Floor of 8003/8
        do_clear("clear_a");
        fill_with(32'd1000, 8, "refill_a");
        strobe_spaced(32'd1003, "floor", 1'b0);
        check_val("floor_ref", reference_counter, 32'd1000);

        // Outlier rejection at tolerance boundary
        do_clear("clear_b");
        fill_with(32'd1000, 8, "refill_b");
        tolerance = 32'd50;
        strobe_spaced(32'd1051, "outlier", 1'b0);
        check_val("outlier_rej", 32'(reject_count), 32'd1);
        strobe_spaced(32'd1050, "edge_ok", 1'b0);
        check_val("edge_ref", reference_counter, 32'd1006);

        // Reset in RUN clears everything
        aresetn = 1'b0;
        model_reset(1'b0);
        push_expect();
        @(posedge clk); #1;
        aresetn = 1'b1;
        check_out("reset_run");
        @(posedge clk); #1;

        // Resync after four consecutive rejects
        tolerance = '0;
        fill_with(32'd1000, 8, "refill_c");
        tolerance = 32'd50;
        burst(4, 32'd2000, 32'd0, "resync");
        check_val("resync_rej", 32'(reject_count), 32'd4);
        check_val("resync_fill", 32'(fill_level), 32'd1);
        fill_with(32'd2000, 7, "resync_fill");
        check_val("resync_ref", reference_counter, 32'd2000);
        check_val("resync_valid", 32'(reference_valid), 32'd1);

        // Back-to-back strobes and a zero sample
        do_clear("clear_d");
        tolerance = '0;
        burst(8, 32'd100, 32'd100, "b2b");
        check_val("b2b_ref", reference_counter, 32'd450);
        strobe_spaced(32'd0, "zero", 1'b0);

        // Clear mid-fill coinciding with a strobe; reject_count held
        do_clear("clear_e");
        fill_with(32'd1000, 5, "midfill");
        clear = 1'b1; period_strobe = 1'b1; last_counter = 32'd1000;
        model_reset(1'b1);
        push_expect();
        @(posedge clk); #1;
        clear = 1'b0; period_strobe = 1'b0; last_counter = '0;
        check_out("clear_strobe");
        push_expect();
        repeat (2) @(posedge clk);
        #1;
        check_out("clear_dropped");

        // Enable low behaves like reset but holds reject_count
        fill_with(32'd1000, 8, "refill_f");
        enable = 1'b0;
        model_reset(1'b1);
        push_expect();
        @(posedge clk); #1;
        check_out("disable");
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
